mult_control_n: RTL and testbench

- Parametrised control FSM for a WIDTH-bit signed (two's complement) shift-add multiplier datapath. The datapath is the A/B/X register chain plus adder/subtractor.
- Replaces the fixed 8-bit enumerated-state controller with a single iteration counter.
- Adds an explicit A/X clear at run start, plus Busy/Done status.
- Drives the datapath register enables only; holds no operand data.

---
 rtl/mult_pkg.sv | 11 +
 rtl/mult_iter_counter.sv | 21 ++
 rtl/mult_control_n.sv | 87 ++++++++
 tb/tb_mult_control_n.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the shift-add multiplier controller
//   mult_state_t   controller states
//   cnt_w(width)   iteration counter width for a given operand width
//   MULT_MAX_WIDTH largest supported operand width
package mult_pkg;
  localparam int MULT_MAX_WIDTH = 32;
  typedef enum logic [2:0] {IDLE, CLRAX, EVAL, SHIFT, DONE} mult_state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/mult_iter_counter.sv
// mult_iter_counter: iteration counter 0..WIDTH-1 with clear, enable and terminal count
//   Clk, Reset  clock, synchronous active-high reset
//   clr, en     synchronous clear (wins over en), count enable
//   cnt         current count
//   tc          high when cnt == WIDTH-1
module mult_iter_counter import mult_pkg::*; #(
  parameter int WIDTH = 8,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  always_ff @(posedge Clk)
    if (Reset || clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/mult_control_n.sv
// mult_control_n: control FSM for a WIDTH-bit signed shift-add multiplier datapath
//   Clk, Reset     clock, synchronous active-high reset
//   Run            start request (level), must drop before the next run starts
//   ClearA_LoadB   in IDLE: clear A/X and load B
//   M              current LSB of B
//   Clr_Ld         clear A/X, load B (IDLE only)
//   Clr_AX         clear A and X at run start
//   Shift          arithmetic right shift of X:A:B
//   Add / Sub      A <= A +/- S; Sub only on the sign bit (last iteration)
//   Busy / Done    run in progress / result ready
//   Iter           current iteration in EVAL/SHIFT, 0 elsewhere
// Build option MULT_SKIP_ZERO_EN: a zero multiplier bit shifts straight from EVAL.
module mult_control_n import mult_pkg::*; #(
  parameter int WIDTH = 8,
  localparam int CW = cnt_w(WIDTH)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          ClearA_LoadB,
  input  logic          M,
  output logic          Clr_Ld,
  output logic          Clr_AX,
  output logic          Shift,
  output logic          Add,
  output logic          Sub,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Iter
);
  if (WIDTH < 2 || WIDTH > MULT_MAX_WIDTH) begin : g_bad_width
    $error("mult_control_n: WIDTH must be in 2..32");
  end
  mult_state_t state, next;
  logic cnt_clr, cnt_en, tc;
  logic [CW-1:0] cnt;
  mult_iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .Clk(Clk), .Reset(Reset), .clr(cnt_clr), .en(cnt_en), .cnt(cnt), .tc(tc)
  );
  always_ff @(posedge Clk)
    if (Reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    Clr_Ld = 1'b0;
    Clr_AX = 1'b0;
    Shift = 1'b0;
    Add = 1'b0;
    Sub = 1'b0;
    cnt_clr = 1'b0;
    cnt_en = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        Clr_Ld = ClearA_LoadB && !Run;
        next = Run ? CLRAX : IDLE;
      end
      CLRAX: begin
        Clr_AX = 1'b1;
        next = EVAL;
      end
      EVAL: begin
        // the sign bit carries negative weight, so the last iteration subtracts
        Add = M && !tc;
        Sub = M && tc;
        next = SHIFT;
`ifdef MULT_SKIP_ZERO_EN
        if (!M) begin
          Shift = 1'b1;
          cnt_en = !tc;
          next = tc ? DONE : EVAL;
        end
`endif
      end
      SHIFT: begin
        Shift = 1'b1;
        cnt_en = !tc;
        next = tc ? DONE : EVAL;
      end
      DONE: next = Run ? DONE : IDLE;
      default: next = IDLE;
    endcase
  end
  assign Busy = state != IDLE && state != DONE;
  assign Done = state == DONE;
  assign Iter = (state == EVAL || state == SHIFT) ? cnt : '0;
endmodule

// File: tb/tb_mult_control_n.sv
// tb_mult_control_n: randomized self-checking bench against a per-cycle strobe sequence model
module tb_mult_control_n;
`ifdef MULT_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic Clk = 0, Reset = 1, Run = 0, Run16 = 0, ClearA_LoadB = 0, M16 = 0;
  logic [31:0] b8 = 0;
  logic M8;
  logic Clr_Ld, Clr_AX, Shift, Add, Sub, Busy, Done;
  logic [2:0] Iter;
  logic Clr_Ld16, Clr_AX16, Shift16, Add16, Sub16, Busy16, Done16;
  logic [3:0] Iter16;
  int total = 0, bad = 0;
  logic [6:0] eq[$];
  int iq[$];
  assign M8 = b8[0];
  always #5 Clk = ~Clk;
  mult_control_n #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M8),
    .Clr_Ld(Clr_Ld), .Clr_AX(Clr_AX), .Shift(Shift), .Add(Add), .Sub(Sub),
    .Busy(Busy), .Done(Done), .Iter(Iter)
  );
  mult_control_n #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .Run(Run16), .ClearA_LoadB(ClearA_LoadB), .M(M16),
    .Clr_Ld(Clr_Ld16), .Clr_AX(Clr_AX16), .Shift(Shift16), .Add(Add16), .Sub(Sub16),
    .Busy(Busy16), .Done(Done16), .Iter(Iter16)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] obs();
    return {Clr_Ld, Clr_AX, Shift, Add, Sub, Busy, Done};
  endfunction
  function automatic logic [6:0] obs16();
    return {Clr_Ld16, Clr_AX16, Shift16, Add16, Sub16, Busy16, Done16};
  endfunction
  // datapath stand-in: B shifts right one place after every Shift edge
  task automatic step();
    logic sh;
    sh = Shift;
    @(posedge Clk);
    #1;
    if (sh) b8 = b8 >> 1;
    @(negedge Clk);
  endtask
  // expected {Clr_Ld,Clr_AX,Shift,Add,Sub,Busy,Done} per cycle from cycle 1 to first Done
  task automatic build(input logic [7:0] b);
    eq = {};
    iq = {};
    eq.push_back(7'b0100010);
    iq.push_back(0);
    for (int i = 0; i < 8; i++) begin
      eq.push_back({2'b00, SKIP && !b[i], b[i] && i != 7, b[i] && i == 7, 2'b10});
      iq.push_back(i);
      if (!SKIP || b[i]) begin
        eq.push_back(7'b0010010);
        iq.push_back(i);
      end
    end
    eq.push_back(7'b0000001);
    iq.push_back(0);
  endtask
  task automatic follow(input bit drop, input int hold);
    logic [6:0] v;
    for (int k = 0; k < eq.size(); k++) begin
      v = obs();
      chk($sformatf("seq%0d", k), v, eq[k]);
      chk($sformatf("iter%0d", k), Iter, iq[k]);
      chk("excl", $countones(v[6:2]) <= 1, 1);
      if (k == 0 && drop) Run = 0;
      if (k < eq.size() - 1) step();
    end
    if (!drop)
      for (int h = 0; h < hold; h++) begin
        step();
        chk("done_hold", obs(), 7'b0000001);
      end
    Run = 0;
    step();
    chk("back_idle", obs(), 7'b0);
    chk("idle_iter", Iter, 0);
  endtask
  task automatic run8(input logic [7:0] b, input bit drop, input int hold);
    build(b);
    b8 = {24'b0, b};
    Run = 1;
    #1;
    chk("idle_run", obs(), 7'b0);
    step();
    follow(drop, hold);
  endtask
  initial begin
    Reset = 1;
    Run = 1;
    build(8'h00);
    b8 = 0;
    @(negedge Clk);
    chk("rst0", obs(), 7'b0);
    step();
    chk("rst1", obs(), 7'b0);
    chk("rst_iter", Iter, 0);
    Reset = 0;
    #1;
    chk("rst_release", obs(), 7'b0);
    step();
    follow(1'b0, 0);
    ClearA_LoadB = 1;
    #1;
    chk("clr_ld", obs(), 7'b1000000);
    build(8'h5A);
    b8 = 32'h5A;
    Run = 1;
    #1;
    chk("run_wins", obs(), 7'b0);
    step();
    ClearA_LoadB = 0;
    follow(1'b1, 0);
    run8(8'hFF, 1'b0, 10);
    run8(8'h81, 1'b0, 0);
    run8(8'h80, 1'b1, 0);
    for (int r = 0; r < 12; r++)
      run8(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    Run16 = 1;
    step();
    Run16 = 0;
    repeat (7) step();
    chk("w16_iter3", Iter16, 3);
    chk("w16_busy", Busy16, 1);
    Reset = 1;
    step();
    Reset = 0;
    chk("w16_rst", obs16(), 7'b0);
    chk("w16_rst_iter", Iter16, 0);
    step();
    chk("w16_idle", obs16(), 7'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
